// File: rtl/ex_div_pkg.sv
// Shared types for the EX-stage RV32M divider: op codes, FSM states and op decode helpers.
package ex_div_pkg;

  localparam int unsigned DivOpW = 2;

  // Low two bits of the RV32M funct3 for DIV/DIVU/REM/REMU.
  typedef enum logic [DivOpW-1:0] {
    DivOpDiv  = 2'd0,
    DivOpDivu = 2'd1,
    DivOpRem  = 2'd2,
    DivOpRemu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StCalc  = 2'd2,
    StEnd   = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DivOpDiv) || (op == DivOpRem);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DivOpRem) || (op == DivOpRemu);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for the EX stage. busy_o feeds the EX wait request;
// ready_o pulses for one cycle in END with the result and its destination register tag.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DivOpW-1:0]     op_i,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state_q, state_d;
  div_op_e    op_q;
  // quot_q holds the raw dividend until START, then the quotient being shifted in.
  logic [XLEN-1:0]       quot_q;
  logic [XLEN-1:0]       rem_q;
  logic [XLEN-1:0]       dvsr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  neg_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       result_q;
  logic [REG_ADDR_W-1:0] rd_out_q;

  logic            signed_op, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [XLEN-1:0] sel, final_val;
  logic            end_ok;

  // Operand decode for START, one trial-subtract step for CALC, sign fix-up for END.
  always_comb begin
    signed_op = op_is_signed(op_q);
    a_neg     = signed_op & quot_q[XLEN-1];
    b_neg     = signed_op & dvsr_q[XLEN-1];
    a_abs     = a_neg ? (~quot_q + 1'b1) : quot_q;
    b_abs     = b_neg ? (~dvsr_q + 1'b1) : dvsr_q;
    div_zero  = (dvsr_q == '0);
    div_ovf   = signed_op && (quot_q == IntMin) && (dvsr_q == '1);

    // rem_q < dvsr_q always, so XLEN+1 bits hold the signed trial difference.
    shifted   = {rem_q, quot_q[XLEN-1]};
    diff      = shifted - {1'b0, dvsr_q};
    ge        = ~diff[XLEN];

    sel       = op_is_rem(op_q) ? rem_q : quot_q;
    final_val = neg_q ? (~sel + 1'b1) : sel;
  end

  // Next-state logic; abort overrides every state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StStart;
      StStart: state_d = (div_zero || div_ovf) ? StEnd : StCalc;
      StCalc:  if (cnt_q == '0) state_d = StEnd;
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) state_d = StIdle;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: latch request, prepare magnitudes or special results, iterate, capture result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= DivOpDiv;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (!abort_i) begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_q   <= div_op_e'(op_i);
            quot_q <= dividend_i;
            dvsr_q <= divisor_i;
            rd_q   <= rd_addr_i;
          end
        end
        StStart: begin
          if (div_zero) begin
            quot_q <= '1;
            rem_q  <= quot_q;
            neg_q  <= 1'b0;
          end else if (div_ovf) begin
            quot_q <= IntMin;
            rem_q  <= '0;
            neg_q  <= 1'b0;
          end else begin
            quot_q <= a_abs;
            dvsr_q <= b_abs;
            rem_q  <= '0;
            cnt_q  <= CntW'(XLEN - 1);
            neg_q  <= op_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
          end
        end
        StCalc: begin
          rem_q  <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], ge};
          cnt_q  <= cnt_q - 1'b1;
        end
        StEnd: begin
          result_q <= final_val;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; the result is presented live during END.
  always_comb begin
    end_ok    = (state_q == StEnd) && !abort_i;
    busy_o    = (state_q == StStart) || (state_q == StCalc);
    ready_o   = end_ok;
    result_o  = end_ok ? final_val : result_q;
    rd_addr_o = end_ok ? rd_q : rd_out_q;
  end

endmodule
